// File: rtl/iterative_priority_encoder_pkg.sv
// Shared types and helpers for the iterative priority encoder.
package iterative_pe_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } pe_state_e;

   function automatic int pe_n(input int encoding_size);
      return 1 << encoding_size;
   endfunction

   // Keep-bit for position pos when clearing the single bit at idx.
   function automatic logic pe_clear_bit(input int unsigned pos, input int unsigned idx);
      return pos != idx;
   endfunction

endpackage

// File: rtl/iterative_priority_encoder_if.sv
// Load/flush/drain handshake bundle of the iterative priority encoder.
// Valid/ready: an index transfers on a rising clock edge where out_valid & out_ready are both high.
interface iterative_priority_encoder_if
   import iterative_pe_pkg::*;
#(
   parameter int EncodingSize = 3
);
   localparam int N = pe_n(EncodingSize);

   logic                    pe_en;
   logic [0:N-1]            in;
   logic                    pe_flush;
   logic [EncodingSize-1:0] out;
   logic                    out_valid;
   logic                    out_ready;
   logic                    pe_busy;
   logic                    pe_finish;
   logic                    pe_empty;
   pe_state_e               state;

   modport master (
      output pe_en, in, pe_flush, out_ready,
      input  out, out_valid, pe_busy, pe_finish, pe_empty, state
   );

   modport slave (
      input  pe_en, in, pe_flush, out_ready,
      output out, out_valid, pe_busy, pe_finish, pe_empty, state
   );
endinterface

// File: rtl/pe_first_set.sv
// Combinational circular search: first set bit of vector at or after start, wrapping past N-1.
module pe_first_set
   import iterative_pe_pkg::*;
#(
   parameter  int EncodingSize = 3,
   localparam int N            = pe_n(EncodingSize)
) (
   input  logic [0:N-1]            vector,
   input  logic [EncodingSize-1:0] start,
   output logic [EncodingSize-1:0] index,
   output logic                    any
);
   logic [EncodingSize-1:0] probe;

   always_comb begin
      index = '0;
      any   = 1'b0;
      probe = start;
      for (int i = 0; i < N; i++) begin
         probe = start + EncodingSize'(i);
         if (!any && vector[probe]) begin
            index = probe;
            any   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/iterative_priority_encoder.sv
// Latches a multi-hot vector and emits each set index over a valid/ready handshake.
// Optional rotating priority when PE_ROUND_ROBIN_EN is defined.
module iterative_priority_encoder
   import iterative_pe_pkg::*;
#(
   parameter int EncodingSize = 3
) (
   input logic                          clock,
   input logic                          reset,
   iterative_priority_encoder_if.slave  bus
);
   localparam int N = pe_n(EncodingSize);

   pe_state_e               state;
   logic [0:N-1]            pending;
   logic [0:N-1]            clear_mask;
   logic [0:N-1]            remaining;
   logic [EncodingSize-1:0] first_idx;
   logic [EncodingSize-1:0] start_idx;
   logic                    first_any;
   logic                    xfer;
   logic                    finish_q;
   logic                    empty_q;

   pe_first_set #(.EncodingSize(EncodingSize)) u_first_set (
      .vector (pending),
      .start  (start_idx),
      .index  (first_idx),
      .any    (first_any)
   );

   assign bus.out_valid = (state == ST_SCAN);
   assign bus.pe_busy   = (state == ST_SCAN);
   assign bus.out       = (state == ST_SCAN && first_any) ? first_idx : '0;
   assign bus.pe_finish = finish_q;
   assign bus.pe_empty  = empty_q;
   assign bus.state     = state;
   assign xfer          = bus.out_valid & bus.out_ready;

   always_comb begin
      clear_mask = '0;
      for (int unsigned i = 0; i < N; i++) begin
         clear_mask[i] = pe_clear_bit(i, int'(first_idx));
      end
      remaining = pending & clear_mask;
   end

`ifdef PE_ROUND_ROBIN_EN
   logic [EncodingSize-1:0] last_idx;

   // A flushed transfer is discarded, so it must not move the pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_idx <= EncodingSize'(N - 1);
      end else if (xfer && !bus.pe_flush) begin
         last_idx <= first_idx;
      end
   end

   assign start_idx = last_idx + 1'b1;
`else
   assign start_idx = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         pending  <= '0;
         finish_q <= 1'b0;
         empty_q  <= 1'b0;
      end else begin
         finish_q <= 1'b0;
         empty_q  <= 1'b0;
         if (bus.pe_flush) begin
            state   <= ST_IDLE;
            pending <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.pe_en) begin
                     if (|bus.in) begin
                        pending <= bus.in;
                        state   <= ST_SCAN;
                     end else begin
                        finish_q <= 1'b1;
                        empty_q  <= 1'b1;
                     end
                  end
               end
               ST_SCAN: begin
                  if (xfer) begin
                     pending <= remaining;
                     if (remaining == '0) begin
                        state    <= ST_IDLE;
                        finish_q <= 1'b1;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/iterative_priority_encoder.md
Name: iterative_priority_encoder

Overview:
- Parametrised, sequential successor to the single-shot priority encoder in the hardware BCP datapath.
- Latches a multi-hot implication/clause vector on `pe_en`, then emits the index of every set bit, one per accepted handshake, in priority order.
- Pulses `pe_finish` when the vector is exhausted.
- Sits between the clause-evaluation array and the implication queue; the downstream queue exerts backpressure through `out_ready`.

Parameters:
- EncodingSize, 3, index width in bits; vector width is N = 2**EncodingSize (localparam, not overridable).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- pe_en  input  1  load strobe; samples `in` when idle.
- in  input  [0:N-1]  request vector; bit 0 is highest priority.
- pe_flush  input  1  abort current vector (BCP conflict).
- out  output  [EncodingSize-1:0]  index of current highest-priority pending bit.
- out_valid  output  1  `out` holds a valid index.
- out_ready  input  1  consumer accepts `out` this cycle.
- pe_busy  output  1  vector loaded and not yet exhausted.
- pe_finish  output  1  one-cycle pulse: vector fully drained, or empty vector loaded.
- pe_empty  output  1  qualifies `pe_finish`: the loaded vector was all-zero.

Behaviour:
- Reset: pending=0; state=IDLE; out=0; out_valid=0; pe_busy=0; pe_finish=0; pe_empty=0. Reset overrides every other input, including mid-scan.
- State machine has two states, IDLE and SCAN. `pending` [0:N-1] is a register.
- IDLE, pe_en=1, in≠0: pending←in; next state SCAN. out_valid rises the next cycle (latency 1).
- IDLE, pe_en=1, in=0: stay in IDLE. Next cycle pe_finish=1 and pe_empty=1 for one cycle.
- IDLE, pe_en=0: hold all state.
- SCAN outputs:
  - out = lowest-numbered set bit of pending (the `pending` bit with the smallest index).
  - out_valid=1; pe_busy=1.
  - out is combinational from registered state, so it is glitch-free relative to clock.
- Handshake: a transfer occurs when out_valid & out_ready.
  - On transfer, that bit is cleared in pending.
  - Without a transfer, out and pending are held stable; out_valid never drops.
- Last bit transferred, with no other bit pending:
  - Next state IDLE.
  - Next cycle pe_finish=1, pe_empty=0, out_valid=0, pe_busy=0.
- Back-to-back: pe_en may be asserted in the same cycle pe_finish is high. The new vector loads because state is IDLE.
- pe_en during SCAN: ignored; no error flag.
- Changes on `in` during SCAN: ignored, since only the latched vector is scanned.
- pe_flush=1 (any state, reset inactive):
  - Next cycle pending=0, state IDLE, out_valid=0, and no pe_finish.
  - Flush beats a simultaneous transfer: the consumer must treat that index as accepted-then-discarded.
  - Flush beats a simultaneous pe_en.
- Throughput: one index per cycle with out_ready held high. An N-hot vector completes in N+1 cycles from pe_en to pe_finish.
- out in IDLE: driven to 0.

Optional Feature:
- Macro: PE_ROUND_ROBIN_EN.
- Defined: a pointer register `last_idx` records the index of the most recent transfer; it resets to N-1.
- Defined, scan order: the search starts at (last_idx+1) mod N and wraps past N-1 to 0. Ordering is thus rotating across vectors and within a vector.
- Defined, flush: the pointer is not changed by flush.
- Defined, wrap rule: mod N wrap is natural EncodingSize-bit overflow.
- Not defined: fixed priority, bit 0 first; no pointer register is synthesised.

Decomposition:
- Shared package iterative_pe_pkg holds:
  - state encoding constants ST_IDLE / ST_SCAN;
  - a function that computes N from EncodingSize;
  - the onehot-clear mask helper.
- Sub-module pe_first_set: purely combinational.
  - Inputs: vector [0:N-1] and start index.
  - Outputs: index and `any` flag.
  - The start index is tied to 0 when round-robin is off.

Test Plan:
- Single bit: reset, then pe_en=1 with in=8'b1000_0000 → next cycle out=0, out_valid=1. With out_ready=1, pe_finish pulses one cycle later and pe_empty=0.
- Multi-hot drain: in=8'b1000_1100 with out_ready=1 → out sequence 0,4,5 on consecutive cycles, then pe_finish. That is 4 cycles after load.
- Backpressure: in=8'b0110_0000 with out_ready=0 for 3 cycles → out=1 held stable with out_valid=1. Then out_ready=1 gives 1,2, then pe_finish.
- Empty vector: pe_en=1 with in=0 → one cycle later pe_finish=1, pe_empty=1, out_valid never asserted.
- Flush mid-scan: in=8'b1111_0000, accept index 0, then pe_flush=1 → out_valid=0 next cycle with no pe_finish. A subsequent pe_en with in=8'b0001_0000 yields out=3.
- Reset mid-scan, plus round-robin under PE_ROUND_ROBIN_EN:
  - Reset while in SCAN → all outputs 0 next cycle.
  - With PE_ROUND_ROBIN_EN defined, last transfer index 4, then in=8'b1000_1100 → order 5,0,4.
